// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (length, payload, checksum),
// writes little-endian 32-bit words to instruction memory and gates the CPU until a verified image is in place.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [23:0] word_asm;

  logic        accept;
  logic [15:0] len_full;
  logic [15:0] next_word;

  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len_lo};
  assign next_word = word_idx + 16'd1;

  // The write strobe is registered off the 4th byte of each word, so the last
  // word's strobe lands in the first CSUM cycle while input keeps flowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
      len_lo       <= 8'd0;
      len          <= 16'd0;
      csum         <= 8'd0;
      byte_idx     <= 2'd0;
      word_idx     <= 16'd0;
      word_asm     <= 24'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= LEN0;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            csum         <= 8'd0;
            byte_idx     <= 2'd0;
            word_idx     <= 16'd0;
            word_asm     <= 24'd0;
          end
        end

        LEN0: begin
          if (accept) begin
            len_lo <= in_data;
            csum   <= csum ^ in_data;
            state  <= LEN1;
          end
        end

        LEN1: begin
          if (accept) begin
            len  <= len_full;
            csum <= csum ^ in_data;
            if ({1'b0, len_full} > MAX_N) begin
              state    <= ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_asm[7:0]   <= in_data;
              2'd1: word_asm[15:8]  <= in_data;
              2'd2: word_asm[23:16] <= in_data;
              default: begin
                mem_we       <= 1'b1;
                mem_addr     <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                mem_wdata    <= {in_data, word_asm};
                words_loaded <= next_word;
                word_idx     <= next_word;
                if (next_word == len) begin
                  state <= CSUM;
                end
              end
            endcase
          end
        end

        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// compared against a frame-level model of expected writes and final status.
module tb_imem_loader;

  localparam int MAX_W = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;
  logic [15:0] exp_wl;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [15:0] got_wl[$];

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(MAX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Record every write strobe seen on the memory port
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      got_wl.push_back(words_loaded);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Expected behaviour after the first nbytes of the frame have been accepted
  task automatic buildModel(input int nbytes);
    int n;
    int complete;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'(frame[0]) + 256 * int'(frame[1]);
    x = frame[0] ^ frame[1];
    exp_done = 0;
    exp_err  = 0;
    exp_wl   = 16'd0;
    if (n > MAX_W) begin
      exp_err = 1;
      return;
    end
    complete = (nbytes - 2) / 4;
    if (complete > n) complete = n;
    for (int k = 0; k < complete; k++) begin
      exp_addr.push_back(32'(4 * k));
      exp_data.push_back({frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]});
    end
    exp_wl = 16'(complete);
    if (nbytes == 2 + 4 * n + 1) begin
      for (int i = 2; i < 2 + 4 * n; i++) x = x ^ frame[i];
      exp_done = (frame[nbytes-1] == x);
      exp_err  = !exp_done;
    end
  endtask

  task automatic makeFrame(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    x = frame[0] ^ frame[1];
    if (n <= MAX_W) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom_range(0, 255));
        frame.push_back(b);
        x = x ^ b;
      end
      frame.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    end
  endtask

  task automatic loadTest1(input logic [7:0] cs);
    frame = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h00, 8'h40, 8'h06, cs};
  endtask

  // Pulse start, then stream nbytes of the frame with random idle gaps
  task automatic applyStimulus(input int nbytes, input int max_gap, input bit inject);
    got_addr.delete();
    got_data.delete();
    got_wl.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", 32'(in_ready), 32'd1);
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
      end
      @(negedge clk);
      start    = inject && (i >= 2) && ($urandom_range(0, 2) == 0);
      in_valid = 1'b1;
      in_data  = frame[i];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic checkWrites(input string tag);
    #1;
    chk({tag, "_wcount"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      chk($sformatf("%s_w%0d_addr", tag, k), got_addr[k], exp_addr[k]);
      chk($sformatf("%s_w%0d_data", tag, k), got_data[k], exp_data[k]);
      chk($sformatf("%s_w%0d_wl", tag, k), 32'(got_wl[k]), 32'(k + 1));
    end
  endtask

  // Called on the cycle right after the final byte: status must already be settled
  task automatic checkOutput(input string tag);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_wl"}, 32'(words_loaded), 32'(exp_wl));
    checkWrites(tag);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_wl"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    $display("[TB] test 1: two-word good frame");
    loadTest1(8'h91);
    buildModel(frame.size());
    applyStimulus(frame.size(), 0, 1'b0);
    checkOutput("t1");
    chk("t1_const_d0", got_data.size() > 0 ? got_data[0] : 32'hxxxxxxxx, 32'h00500513);
    chk("t1_const_d1", got_data.size() > 1 ? got_data[1] : 32'hxxxxxxxx, 32'h06400093);

    $display("[TB] test 2: bad checksum");
    loadTest1(8'h90);
    buildModel(frame.size());
    applyStimulus(frame.size(), 0, 1'b0);
    checkOutput("t2");

    $display("[TB] test 3: empty frames");
    frame = {8'h00, 8'h00, 8'h00};
    buildModel(frame.size());
    applyStimulus(frame.size(), 2, 1'b0);
    checkOutput("t3a");
    frame = {8'h00, 8'h00, 8'h01};
    buildModel(frame.size());
    applyStimulus(frame.size(), 2, 1'b0);
    checkOutput("t3b");

    $display("[TB] test 4: oversized header");
    frame = {8'h01, 8'h01};
    buildModel(frame.size());
    applyStimulus(frame.size(), 0, 1'b0);
    checkOutput("t4");

    $display("[TB] test 5: gaps and stray start pulses");
    loadTest1(8'h91);
    buildModel(frame.size());
    applyStimulus(frame.size(), 7, 1'b1);
    checkOutput("t5");

    $display("[TB] test 6: reset mid-frame");
    loadTest1(8'h91);
    buildModel(6);
    applyStimulus(6, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkReset("t6_rst");
    rst = 1'b0;
    checkWrites("t6_partial");
    buildModel(frame.size());
    applyStimulus(frame.size(), 1, 1'b0);
    checkOutput("t6_reload");

    $display("[TB] boundary: N == MAX_WORDS");
    makeFrame(MAX_W, 1'b1);
    buildModel(frame.size());
    applyStimulus(frame.size(), 0, 1'b0);
    checkOutput("max");

    $display("[TB] randomized frames");
    for (int r = 0; r < 10; r++) begin
      if (r == 9) makeFrame($urandom_range(MAX_W + 1, 65535), 1'b1);
      else makeFrame($urandom_range(0, 6), $urandom_range(0, 3) != 0);
      buildModel(frame.size());
      applyStimulus(frame.size(), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
      checkOutput($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed program image as a byte stream (typically from the UART receiver) and writes 32-bit words into a writable instruction memory at PC-compatible byte addresses.
- Holds the CPU in stall/reset while loading. Releases the CPU only after a verified, complete image has been written.

Parameters:
- BASE_ADDR, 32'd0, byte address of the first written word; must be word-aligned.
- MAX_WORDS, 256, largest accepted word count; larger headers are rejected.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse that begins a load.
- in_data  input  8  received byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte. A byte transfers when in_valid && in_ready on a rising clk edge.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  32  write byte address (word-aligned).
- mem_wdata  output  32  write data.
- cpu_hold  output  1  keeps the CPU stalled and its PC at 0 while high.
- done  output  1  a verified load is complete.
- error  output  1  the load failed.
- words_loaded  output  16  number of words written in the current or last load.

Behaviour:
- Frame format: LEN_L, LEN_H (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian, least significant byte first), then CSUM.
- Valid frame condition: CSUM == XOR of LEN_L, LEN_H and all payload bytes.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- Reset values (rst high, applied at the clock edge):
  - state = IDLE.
  - cpu_hold = 1, in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, done = 0, error = 0, words_loaded = 0.
  - Internal byte index, word index and checksum = 0.
- IDLE, DONE, ERROR + start:
  - Go to LEN0.
  - Clear done, error, words_loaded and checksum.
  - Set cpu_hold = 1.
- start in LEN0, LEN1, DATA or CSUM: ignored.
- in_ready = 1 exactly in LEN0, LEN1, DATA and CSUM. It is never deasserted mid-frame; writes are registered and never stall input.
- LEN0: on accept, latch LEN_L and XOR it into the checksum; go to LEN1.
- LEN1 on accept: latch LEN_H and XOR it into the checksum, then:
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: each accepted byte shifts into the word assembly register at byte lane = byte index mod 4, and is XORed into the checksum.
- Word write, on the cycle after the 4th byte of word k is accepted:
  - mem_we = 1 for exactly one cycle.
  - mem_addr = BASE_ADDR + 4*k (32-bit wrap).
  - mem_wdata = the assembled word.
  - words_loaded = k+1, in the same cycle as the strobe.
- After word N-1 is accepted, go to CSUM. Its write strobe occurs in the first CSUM cycle.
- CSUM on accept:
  - Byte matches the checksum: go to DONE.
  - Mismatch: go to ERROR.
  - Words already written are not rolled back.
- DONE: done = 1, cpu_hold = 0, in_ready = 0. Held until start or rst.
- ERROR: error = 1, cpu_hold = 1, in_ready = 0. Held until start or rst.
- Gaps on in_valid (any length) only pause progress; no timeout.
- rst mid-frame: immediate return to reset values. A pending write strobe is dropped. Partially assembled word is discarded.
- mem_we is never asserted outside DATA or the first CSUM cycle.

Test Plan:
1. start; bytes 02 00 13 05 50 00 93 00 40 06 91 -> writes (addr 0x0, data 0x00500513) then (addr 0x4, data 0x06400093); done=1, cpu_hold=0, words_loaded=2.
2. Same frame with CSUM 0x90 -> both writes occur; error=1, done=0, cpu_hold=1, in_ready=0.
3. start; bytes 00 00 00 -> no mem_we; done=1, words_loaded=0. Variant with CSUM 0x01 -> error=1.
4. start; bytes 01 01 (N=257) -> error=1 on the cycle after LEN_H; in_ready=0; no writes.
5. Frame from test 1 with in_valid randomly low 0-7 cycles between bytes, and start pulses injected during DATA -> identical writes and result to test 1.
6. rst asserted after the 6th byte of the test-1 frame -> all outputs at reset values, no write of word 1. Then a fresh test-1 frame -> done=1 with correct writes.
